// File: rtl/fetch_pkg.sv
// Shared widths, bundle entry layout and slot extraction for the fetch queue.
// Used by bundle_queue_storage and fetch_bundle_queue.
package fetch_pkg;

    localparam int ADDR_W       = 64;
    localparam int INST_W       = 32;
    localparam int BUNDLE_SLOTS = 4;
    localparam int BUNDLE_W     = INST_W * BUNDLE_SLOTS;
    localparam int PID_W        = 20;
    localparam int TID_W        = 16;
    localparam int MAJID_W      = 64;
    localparam int LEN_W        = 2;

    typedef struct packed {
        logic [BUNDLE_W-1:0] bundle;
        logic [ADDR_W-1:0]   addr;
        logic [LEN_W-1:0]    len;
        logic [PID_W-1:0]    pid;
        logic [TID_W-1:0]    tid;
        logic [MAJID_W-1:0]  majId;
    } bundle_entry_t;

    // Slot 0 sits in the most significant word of the bundle.
    function automatic logic [INST_W-1:0] slot_word(
        input logic [BUNDLE_W-1:0] b,
        input logic [LEN_W-1:0]    k
    );
        logic [BUNDLE_W-1:0] s;
        s = b << (INST_W * int'(k));
        return s[BUNDLE_W-1 -: INST_W];
    endfunction

endpackage

// File: rtl/bundle_queue_storage.sv
// Circular bundle array with write/read pointers and occupancy count.
// Flush clears pointers and count; entry contents are never reset.
module bundle_queue_storage
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          wrEn_i,
    input  bundle_entry_t wrEntry_i,
    input  logic          pop_i,
    output bundle_entry_t head_o,
    output logic [CW-1:0] count_o
);

    bundle_entry_t mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrEn_i) wrPtr_d = wrPtr_q + PW'(1);
            if (pop_i)  rdPtr_d = rdPtr_q + PW'(1);
            case ({wrEn_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wrEn_i) mem_q[wrPtr_q] <= wrEntry_i;
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_bundle_queue.sv
// Fetch bundle queue: buffers I-cache bundles, issues one instruction per cycle.
// FETCH_QUEUE_PERF_EN adds saturating stall/empty/drop counters.
module fetch_bundle_queue
    import fetch_pkg::*;
#(
    parameter int queueDepth  = 4,
    parameter int stallMargin = 2
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                bundleValid_i,
    input  logic [BUNDLE_W-1:0] bundle_i,
    input  logic [ADDR_W-1:0]   bundleAddress_i,
    input  logic [LEN_W-1:0]    bundleLen_i,
    input  logic [PID_W-1:0]    bundlePid_i,
    input  logic [TID_W-1:0]    bundleTid_i,
    input  logic [MAJID_W-1:0]  bundleStartMajId_i,
    input  logic                flush_i,
    input  logic                decodeStall_i,
    output logic                fetchStall_o,
    output logic                instValid_o,
    output logic [INST_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   instAddress_o,
    output logic [PID_W-1:0]    instPid_o,
    output logic [TID_W-1:0]    instTid_o,
    output logic [MAJID_W-1:0]  instMajId_o,
    output logic                overflow_o
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]         perfStallCycles_o,
    output logic [31:0]         perfEmptyCycles_o,
    output logic [31:0]         perfDropped_o
`endif
);

    localparam int CW = $clog2(queueDepth) + 1;

    bundle_entry_t    wrEntry, head;
    logic [CW-1:0]    count;
    logic [LEN_W-1:0] slot_q, slot_d;
    logic             overflow_q, overflow_d;
    logic             full, valid, adv, last, wrEn, pop, drop;

    assign wrEntry = '{bundle: bundle_i, addr: bundleAddress_i,
                       len: bundleLen_i, pid: bundlePid_i,
                       tid: bundleTid_i, majId: bundleStartMajId_i};

    assign full  = count == CW'(queueDepth);
    assign valid = count != '0;
    assign adv   = valid && !decodeStall_i;
    assign last  = slot_q == head.len;
    assign wrEn  = bundleValid_i && !full && !flush_i;
    assign drop  = bundleValid_i && full && !flush_i;
    assign pop   = adv && last && !flush_i;

    assign fetchStall_o = (CW'(queueDepth) - count) <= CW'(stallMargin);

    bundle_queue_storage #(.DEPTH(queueDepth)) u_storage (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .flush_i   (flush_i),
        .wrEn_i    (wrEn),
        .wrEntry_i (wrEntry),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (count)
    );

    always_comb begin
        slot_d     = slot_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            slot_d = '0;
        end else if (adv) begin
            slot_d = last ? '0 : slot_q + LEN_W'(1);
        end
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            slot_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

    // Data outputs are forced to zero whenever nothing is presented.
    always_comb begin
        instValid_o   = valid;
        inst_o        = '0;
        instAddress_o = '0;
        instPid_o     = '0;
        instTid_o     = '0;
        instMajId_o   = '0;
        if (valid) begin
            inst_o        = slot_word(head.bundle, slot_q);
            instAddress_o = head.addr + {{(ADDR_W-4){1'b0}}, slot_q, 2'b00};
            instPid_o     = head.pid;
            instTid_o     = head.tid;
            instMajId_o   = head.majId + {{(MAJID_W-2){1'b0}}, slot_q};
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stallCnt_q, emptyCnt_q, dropCnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stallCnt_q <= '0;
            emptyCnt_q <= '0;
            dropCnt_q  <= '0;
        end else begin
            if (fetchStall_o && stallCnt_q != '1) stallCnt_q <= stallCnt_q + 32'd1;
            if (!valid && emptyCnt_q != '1)       emptyCnt_q <= emptyCnt_q + 32'd1;
            if (drop && dropCnt_q != '1)          dropCnt_q  <= dropCnt_q + 32'd1;
        end
    end

    assign perfStallCycles_o = stallCnt_q;
    assign perfEmptyCycles_o = emptyCnt_q;
    assign perfDropped_o     = dropCnt_q;
`endif

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Bench for fetch_bundle_queue: queue-of-bundles model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_bundle_queue;

    localparam int D = 4;
    localparam int M = 2;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         bundleValid_i = 1'b0;
    logic [127:0] bundle_i = '0;
    logic [63:0]  bundleAddress_i = '0;
    logic [1:0]   bundleLen_i = '0;
    logic [19:0]  bundlePid_i = '0;
    logic [15:0]  bundleTid_i = '0;
    logic [63:0]  bundleStartMajId_i = '0;
    logic         flush_i = 1'b0;
    logic         decodeStall_i = 1'b0;
    logic         fetchStall_o, instValid_o, overflow_o;
    logic [31:0]  inst_o;
    logic [63:0]  instAddress_o, instMajId_o;
    logic [19:0]  instPid_o;
    logic [15:0]  instTid_o;

    fetch_bundle_queue #(.queueDepth(D), .stallMargin(M)) dut (
        .clock_i            (clk),
        .reset_i            (reset_i),
        .bundleValid_i      (bundleValid_i),
        .bundle_i           (bundle_i),
        .bundleAddress_i    (bundleAddress_i),
        .bundleLen_i        (bundleLen_i),
        .bundlePid_i        (bundlePid_i),
        .bundleTid_i        (bundleTid_i),
        .bundleStartMajId_i (bundleStartMajId_i),
        .flush_i            (flush_i),
        .decodeStall_i      (decodeStall_i),
        .fetchStall_o       (fetchStall_o),
        .instValid_o        (instValid_o),
        .inst_o             (inst_o),
        .instAddress_o      (instAddress_o),
        .instPid_o          (instPid_o),
        .instTid_o          (instTid_o),
        .instMajId_o        (instMajId_o),
        .overflow_o         (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] b;
        logic [63:0]  a;
        logic [1:0]   l;
        logic [19:0]  p;
        logic [15:0]  t;
        logic [63:0]  m;
    } bun_t;

    bun_t mq[$];
    int   cons = 0;
    bit   movf = 1'b0;
    bit   live = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input bun_t x, input int c);
        return x.b[127 - 32*c -: 32];
    endfunction

    // Model: a queue of whole bundles plus the number of instructions
    // already consumed from the head bundle.
    always @(posedge clk) begin
        bit   full;
        bun_t nb;
        if (reset_i) begin
            mq.delete();
            cons = 0;
            movf = 1'b0;
            live = 1'b1;
        end else if (flush_i) begin
            mq.delete();
            cons = 0;
        end else begin
            full = (mq.size() == D);
            if (mq.size() != 0 && !decodeStall_i) begin
                cons++;
                if (cons > int'(mq[0].l)) begin
                    void'(mq.pop_front());
                    cons = 0;
                end
            end
            if (bundleValid_i) begin
                if (full) movf = 1'b1;
                else begin
                    nb.b = bundle_i;
                    nb.a = bundleAddress_i;
                    nb.l = bundleLen_i;
                    nb.p = bundlePid_i;
                    nb.t = bundleTid_i;
                    nb.m = bundleStartMajId_i;
                    mq.push_back(nb);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit v;
        if (live) begin
            v = (mq.size() != 0);
            chk("valid", 64'(instValid_o), 64'(v));
            chk("fetchStall", 64'(fetchStall_o), 64'((D - mq.size()) <= M));
            chk("overflow", 64'(overflow_o), 64'(movf));
            if (v) begin
                chk("inst", 64'(inst_o), 64'(word_of(mq[0], cons)));
                chk("addr", instAddress_o, mq[0].a + 64'(4 * cons));
                chk("pid", 64'(instPid_o), 64'(mq[0].p));
                chk("tid", 64'(instTid_o), 64'(mq[0].t));
                chk("majId", instMajId_o, mq[0].m + 64'(cons));
            end else begin
                chk("inst_zero", 64'(inst_o), 64'd0);
                chk("addr_zero", instAddress_o, 64'd0);
                chk("pid_zero", 64'(instPid_o), 64'd0);
                chk("tid_zero", 64'(instTid_o), 64'd0);
                chk("majId_zero", instMajId_o, 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_b(input logic [127:0] b, input logic [63:0] a,
                         input logic [1:0] l, input logic [63:0] m);
        bundle_i           = b;
        bundleAddress_i    = a;
        bundleLen_i        = l;
        bundleStartMajId_i = m;
        bundlePid_i        = 20'($urandom);
        bundleTid_i        = 16'($urandom);
    endtask

    task automatic lit(input string nm, input logic [31:0] w,
                       input logic [63:0] a, input logic [63:0] m);
        chk({nm, "_valid"}, 64'(instValid_o), 64'd1);
        chk({nm, "_inst"}, 64'(inst_o), 64'(w));
        chk({nm, "_addr"}, instAddress_o, a);
        chk({nm, "_maj"}, instMajId_o, m);
    endtask

    task automatic fill5();
        decodeStall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_b({32'h10 + 32'(i), 32'h20 + 32'(i), 32'h30 + 32'(i), 32'h40 + 32'(i)},
                  64'h1000 * 64'(i + 1), 2'(i % 4), 64'(1000 * i));
            bundleValid_i = 1'b1;
            cyc();
            if (i == 0) chk("stall_cnt1", 64'(fetchStall_o), 64'd0);
            if (i == 1) chk("stall_cnt2", 64'(fetchStall_o), 64'd1);
        end
        bundleValid_i = 1'b0;
        chk("ovf_after5", 64'(overflow_o), 64'd1);
    endtask

    initial begin
        int k;
        cyc();
        cyc();
        chk("rst_valid", 64'(instValid_o), 64'd0);
        chk("rst_stall", 64'(fetchStall_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        reset_i = 1'b0;
        cyc();
        chk("idle_valid", 64'(instValid_o), 64'd0);

        // single 4-instruction bundle
        set_b({32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}, 64'h40, 2'd3, 64'd100);
        bundleValid_i = 1'b1;
        cyc();
        bundleValid_i = 1'b0;
        lit("b0s0", 32'hAAAAAAAA, 64'h40, 64'd100);
        cyc();
        lit("b0s1", 32'hBBBBBBBB, 64'h44, 64'd101);
        cyc();
        lit("b0s2", 32'hCCCCCCCC, 64'h48, 64'd102);
        cyc();
        lit("b0s3", 32'hDDDDDDDD, 64'h4C, 64'd103);
        cyc();
        chk("b0_done", 64'(instValid_o), 64'd0);

        // fill under decode stall, fifth bundle dropped, then drain
        fill5();
        lit("full_head", 32'h10, 64'h1000, 64'd0);
        decodeStall_i = 1'b0;
        k = 0;
        while (instValid_o && k < 40) begin
            cyc();
            k++;
        end
        chk("drain_cycles", 64'(k), 64'd10);
        chk("drained", 64'(instValid_o), 64'd0);

        // len 0 then len 1: pop and write in the same cycle
        set_b({32'h11111111, 96'h0}, 64'h80, 2'd0, 64'd7);
        bundleValid_i = 1'b1;
        cyc();
        lit("l0", 32'h11111111, 64'h80, 64'd7);
        set_b({32'h22222222, 32'h33333333, 64'h0}, 64'h90, 2'd1, 64'd8);
        cyc();
        bundleValid_i = 1'b0;
        lit("l1s0", 32'h22222222, 64'h90, 64'd8);
        cyc();
        lit("l1s1", 32'h33333333, 64'h94, 64'd9);
        cyc();
        chk("l1_done", 64'(instValid_o), 64'd0);

        // flush mid-bundle with a simultaneous incoming bundle
        set_b({32'hA0, 32'hA1, 32'hA2, 32'hA3}, 64'h200, 2'd3, 64'd50);
        bundleValid_i = 1'b1;
        cyc();
        bundleValid_i = 1'b0;
        cyc();
        cyc();
        lit("pre_flush", 32'hA2, 64'h208, 64'd52);
        flush_i = 1'b1;
        set_b({4{32'hEE}}, 64'h300, 2'd3, 64'd60);
        bundleValid_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        bundleValid_i = 1'b0;
        chk("flush_valid", 64'(instValid_o), 64'd0);
        chk("flush_ovf", 64'(overflow_o), 64'd1);
        chk("flush_stall", 64'(fetchStall_o), 64'd0);
        cyc();
        chk("flush_valid2", 64'(instValid_o), 64'd0);

        // address and major ID wrap at 2^64
        set_b({32'h1, 32'h2, 32'h3, 32'h4}, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, '1);
        bundleValid_i = 1'b1;
        cyc();
        bundleValid_i = 1'b0;
        lit("w0", 32'h1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        lit("w1", 32'h2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        cyc();
        lit("w2", 32'h3, 64'h0, 64'd1);
        cyc();
        lit("w3", 32'h4, 64'h4, 64'd2);
        cyc();

        // reset while full and overflowed
        fill5();
        reset_i = 1'b1;
        bundleValid_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        bundleValid_i = 1'b0;
        decodeStall_i = 1'b0;
        chk("rst2_valid", 64'(instValid_o), 64'd0);
        chk("rst2_inst", 64'(inst_o), 64'd0);
        chk("rst2_addr", instAddress_o, 64'd0);
        chk("rst2_pid", 64'(instPid_o), 64'd0);
        chk("rst2_tid", 64'(instTid_o), 64'd0);
        chk("rst2_maj", instMajId_o, 64'd0);
        chk("rst2_stall", 64'(fetchStall_o), 64'd0);
        chk("rst2_ovf", 64'(overflow_o), 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_b({$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 7) == 0) ? {32'hFFFFFFFF, 32'hFFFFFFF0 | 32'($urandom_range(0, 15))}
                                               : {$urandom, $urandom},
                  2'($urandom), {$urandom, $urandom});
            bundleValid_i = ($urandom_range(0, 2) != 0);
            decodeStall_i = ($urandom_range(0, 2) == 0);
            flush_i       = ($urandom_range(0, 63) == 0);
            reset_i       = ($urandom_range(0, 499) == 0);
            cyc();
        end
        reset_i = 1'b0;
        flush_i = 1'b0;
        bundleValid_i = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_bundle_queue.md
Name: fetch_bundle_queue

Overview:
Sits directly downstream of the L1 instruction cache.
- Captures each fetched bundle (up to 4 instructions, address, length, PID/TID, starting major ID) into a circular queue.
- Hands instructions to decode one per cycle, with the per-instruction address and major ID.
- Back-pressures the cache through fetchStall_o before the queue can overflow.

Parameters:
fetchingAddressWidth, 64, address width
instructionWidth, 32, POWER fixed instruction width
bundleSize, 128, 4*instructionWidth
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major ID width
queueDepth, 4, bundle entries; power of two, >=4
stallMargin, 2, free entries at/below which fetchStall_o asserts; must be < queueDepth

Ports:
clock_i  in  1  clock, rising edge
reset_i  in  1  synchronous, active-high reset
bundleValid_i  in  1  bundle present from the cache
bundle_i  in  bundleSize  instructions; slot k = bits [32k:32k+31], bit 0 = MSB
bundleAddress_i  in  fetchingAddressWidth  address of slot 0
bundleLen_i  in  2  instruction count minus 1
bundlePid_i  in  PidSize  process ID
bundleTid_i  in  TidSize  thread ID
bundleStartMajId_i  in  instructionCounterWidth  major ID of slot 0
flush_i  in  1  discard all queued state
decodeStall_i  in  1  decode cannot accept this cycle
fetchStall_o  out  1  back-pressure to the cache
instValid_o  out  1  instruction presented
inst_o  out  instructionWidth  instruction word
instAddress_o  out  fetchingAddressWidth  instruction address
instPid_o  out  PidSize  process ID
instTid_o  out  TidSize  thread ID
instMajId_o  out  instructionCounterWidth  instruction major ID
overflow_o  out  1  sticky: a bundle was dropped

Behaviour:
- State: entry array, wrPtr, rdPtr (log2(queueDepth) bits, wrapping mod queueDepth), count (log2(queueDepth)+1 bits), slotIdx (2 bits).
- Reset (synchronous, highest priority): pointers, count, slotIdx, overflow_o all cleared. Entry contents are don't-care.
- Reset output values: instValid_o=0, all inst* data outputs=0, fetchStall_o=0, overflow_o=0.
- Write: on bundleValid_i && count<queueDepth && !flush_i, store the entry at wrPtr and increment wrPtr.
- Write while full: bundle dropped, overflow_o set, no state change. Full is judged on count before any same-cycle pop, so the write is rejected even if a pop happens that cycle.
- Presentation: instValid_o = (count!=0), combinational from the head entry.
  - inst_o = slot slotIdx of the head bundle.
  - instAddress_o = headAddr + 4*slotIdx, mod 2^64.
  - instMajId_o = headMajId + slotIdx, mod 2^64.
  - When instValid_o=0, all data outputs are driven to 0.
- Latency: a bundle accepted on edge N is first presented after edge N, never in the same cycle it arrives.
- Advance: on instValid_o && !decodeStall_i:
  - slotIdx<headLen: slotIdx increments.
  - slotIdx==headLen: pop, i.e. increment rdPtr and reset slotIdx to 0.
- Simultaneous accepted write and pop: count unchanged.
- fetchStall_o = (queueDepth-count) <= stallMargin, combinational from registered count.
- flush_i (below reset in priority): count, pointers and slotIdx cleared. Same-cycle write and advance are ignored. instValid_o=0 next cycle. overflow_o is kept.
- decodeStall_i while empty: no effect.
- bundleLen_i=3 with bundleAddress_i near 2^64: address wraps modulo 2^64.

Optional Feature:
FETCH_QUEUE_PERF_EN
- Defined: adds three 32-bit saturating counters, cleared by reset only (not flush):
  - perfStallCycles_o: cycles with fetchStall_o=1.
  - perfEmptyCycles_o: cycles with count==0.
  - perfDropped_o: bundles dropped.
- Undefined: the three ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - width constants: address, instruction, bundle, PID, TID, major ID;
  - the bundle entry struct/typedef {bundle, addr, len, pid, tid, majId};
  - the BUNDLE_SLOTS=4 constant.
- One sub-module, bundle_queue_storage: circular entry array with its pointers and count, write/pop/flush inputs, head entry output.
- Top level holds slotIdx, the extraction/offset arithmetic, stall generation and the overflow flag.

Test Plan:
- Reset, then idle -> instValid_o=0, fetchStall_o=0, overflow_o=0.
- One bundle: addr 0x40, len 3, majId 100, 32-bit words AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD; decodeStall_i=0 -> over 4 cycles the outputs are (AAAAAAAA, 0x40, 100), (BBBBBBBB, 0x44, 101), (CCCCCCCC, 0x48, 102), (DDDDDDDD, 0x4C, 103), then instValid_o=0.
- decodeStall_i=1 while bundles arrive each cycle -> fetchStall_o rises at count=2. The 5th bundle is dropped and overflow_o=1. Release stall -> the first 4 bundles drain in order.
- Bundle with len 0 followed by bundle with len 1 -> 3 instructions presented back-to-back; a pop and a write in the same cycle leave count unchanged.
- flush_i asserted mid-bundle (slotIdx=2) together with bundleValid_i -> next cycle instValid_o=0, count=0, the incoming bundle is dropped, overflow_o is unchanged.
- reset_i asserted while the queue is full and overflow_o=1 -> next cycle all outputs are at their reset values.
